prog_seq_detector: RTL and testbench

Parametrised, runtime-programmable serial sequence detector with Moore-type match output. It samples one bit per accepted cycle from a serial stream and raises `w` when the last `len` accepted bits equal a loaded pattern. Overlapping or non-overlapping detection is selectable, and a saturating counter tracks matches. It sits on the serial input path wherever the design needs to recognise a fixed or configurable bit sequence. Reset defaults reproduce a "10010" overlapping detector without any configuration.

---
 rtl/prog_seq_detector.sv | 159 +++++++++++++++
 tb/tb_prog_seq_detector.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_seq_detector.sv
// -----------------------------------------------------------------------------
// prog_seq_detector
//
// Runtime-programmable serial sequence detector with a registered (Moore)
// match output. One bit is sampled per accepted cycle. When the most recent
// `len` accepted bits equal the low `len` bits of the loaded pattern, `w` rises
// and a saturating match counter increments. Detection is either overlapping
// (the bits of a match may start the next one) or non-overlapping (the
// history fill is cleared after every match).
//
// Out of reset the block behaves as a "10010" overlapping detector, so it
// needs no configuration.
//
// Parameters
//   MAX_LEN : maximum pattern length in bits (>= 5)
//   CNT_W   : width of the match counter
//   LEN_W   : width of the length field, derived from MAX_LEN
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   cfg_load    in   load cfg_pattern / cfg_len / cfg_overlap this edge
//   cfg_pattern in   pattern; bit [len-1] is received first, bit [0] last
//   cfg_len     in   pattern length, legal range 1..MAX_LEN
//   cfg_overlap in   1 = overlapping detection, 0 = non-overlapping
//   in_valid    in   j is accepted this edge
//   j           in   serial data bit
//   w           out  match indicator, registered
//   match_cnt   out  number of matches since the last clear, saturating
//   cfg_err     out  last load carried an illegal length; detector disabled
// -----------------------------------------------------------------------------
module prog_seq_detector #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               j,
    output logic               w,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    // Reset configuration: "10010", length 5, overlapping.
    localparam logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(5'b10010);
    localparam logic [LEN_W-1:0]   RST_LEN = LEN_W'(5);
    localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);

    // Detector state. The control state is implicit in fill_q / w_q / err_q:
    //   FILLING  : fill_q <  len_q
    //   ARMED    : fill_q == len_q and w_q == 0
    //   MATCH    : w_q == 1
    //   DISABLED : err_q == 1
    logic [MAX_LEN-1:0] pat_q,  pat_d;
    logic [LEN_W-1:0]   len_q,  len_d;
    logic               ovl_q,  ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               w_q,    w_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;
    logic               err_q,  err_d;

    // Datapath helpers for the accept path.
    logic [MAX_LEN-1:0] hist_n;     // history including the incoming bit
    logic [LEN_W-1:0]   fill_inc;   // fill after this bit, saturated at len
    logic [MAX_LEN-1:0] len_mask;   // ones in the low len_q positions
    logic [MAX_LEN-1:0] diff;       // per-bit pattern disagreement
    logic               pat_eq;
    logic               hit;
    logic               accept;
    logic               len_bad;

    assign hist_n   = {hist_q[MAX_LEN-2:0], j};
    assign fill_inc = (fill_q >= len_q) ? len_q : fill_q + 1'b1;

    // Only the newest len_q bits take part in the comparison; older history
    // bits and the unused upper pattern bits are masked out.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign len_mask[gi] = (LEN_W'(gi) < len_q);
            assign diff[gi]     = (hist_n[gi] ^ pat_q[gi]) & len_mask[gi];
        end
    endgenerate

    assign pat_eq  = (diff == '0);
    assign hit     = (fill_inc == len_q) && pat_eq;
    assign accept  = in_valid && !err_q;
    assign len_bad = (cfg_len == '0) || (cfg_len > MAX_LEN_L);

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        w_d    = w_q;
        cnt_d  = cnt_q;
        err_d  = err_q;

        if (cfg_load) begin
            // A load wins over a simultaneous data bit; that bit is dropped.
            pat_d  = cfg_pattern;
            len_d  = cfg_len;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
            w_d    = 1'b0;
            cnt_d  = '0;
            err_d  = len_bad;
        end else if (accept) begin
            hist_d = hist_n;
            w_d    = hit;
            if (hit) begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Non-overlapping mode restarts the fill so no bit of this
                // match can contribute to the next one.
                fill_d = ovl_q ? fill_inc : '0;
            end else begin
                fill_d = fill_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= RST_PAT;
            len_q  <= RST_LEN;
            ovl_q  <= 1'b1;
            hist_q <= '0;
            fill_q <= '0;
            w_q    <= 1'b0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            w_q    <= w_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign w         = w_q;
    assign match_cnt = cnt_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_prog_seq_detector.sv
// -----------------------------------------------------------------------------
// tb_prog_seq_detector
//
// Scoreboard bench for prog_seq_detector. The stimulus process drives one
// directed vector per cycle and pushes the hand-computed response into a
// queue; the monitor pops and compares after every checked edge. A second
// instance with a 2-bit counter covers counter saturation.
// -----------------------------------------------------------------------------
module tb_prog_seq_detector;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN) + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               j;
    logic               w_a, w_b;
    logic [7:0]         cnt_a;
    logic [1:0]         cnt_b;
    logic               err_a, err_b;

    logic               chk_en;
    logic               cur_sel;
    logic [7:0]         pv;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       sel;
        logic       ew;
        logic [7:0] ec;
        logic       ee;
        string      nm;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    prog_seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .j(j), .w(w_a), .match_cnt(cnt_a), .cfg_err(err_a)
    );

    prog_seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .j(j), .w(w_b), .match_cnt(cnt_b), .cfg_err(err_b)
    );

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One checked cycle of stimulus.
    task automatic drive(input logic ld, input logic [MAX_LEN-1:0] p,
                         input logic [LEN_W-1:0] l, input logic o,
                         input logic v, input logic jb,
                         input logic ew, input logic [7:0] ec, input logic ee,
                         input string nm);
        exp_t e;
        @(negedge clk);
        cfg_load    = ld;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        in_valid    = v;
        j           = jb;
        chk_en      = 1'b1;
        e.sel = cur_sel; e.ew = ew; e.ec = ec; e.ee = ee; e.nm = nm;
        sb_q.push_back(e);
    endtask

    task automatic acc(input logic jb, input logic ew, input logic [7:0] ec,
                       input logic ee, input string nm);
        drive(1'b0, '0, '0, 1'b0, 1'b1, jb, ew, ec, ee, nm);
    endtask

    task automatic gap(input logic ew, input logic [7:0] ec, input string nm);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ew, ec, 1'b0, nm);
    endtask

    task automatic ld(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                      input logic o, input logic v, input logic jb,
                      input logic ee, input string nm);
        drive(1'b1, p, l, o, v, jb, 1'b0, 8'd0, ee, nm);
    endtask

    task automatic quiet();
        @(negedge clk);
        cfg_load = 1'b0;
        in_valid = 1'b0;
        chk_en   = 1'b0;
    endtask

    // Asynchronous reset pulse between clock edges, checked before any edge.
    task automatic rst_pulse(input string nm);
        quiet();
        #2 rst = 1'b1;
        #1;
        cmp({nm, " w"},   {7'd0, w_a},   8'd0);
        cmp({nm, " cnt"}, cnt_a,         8'd0);
        cmp({nm, " err"}, {7'd0, err_a}, 8'd0);
        #1 rst = 1'b0;
    endtask

    // Monitor: every edge on which the bench marked a checked vector.
    initial begin
        exp_t e;
        logic c;
        logic aw, ae;
        logic [7:0] ac;
        forever begin
            @(posedge clk);
            c = chk_en;
            #1;
            if (c) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL scoreboard: got empty queue, expected an entry");
                end else begin
                    e  = sb_q.pop_front();
                    aw = e.sel ? w_b : w_a;
                    ac = e.sel ? {6'd0, cnt_b} : cnt_a;
                    ae = e.sel ? err_b : err_a;
                    $display("%0t %s dut=%0d w=%0b cnt=%0d err=%0b", $time, e.nm,
                             e.sel, aw, ac, ae);
                    cmp({e.nm, " w"},   {7'd0, aw}, {7'd0, e.ew});
                    cmp({e.nm, " cnt"}, ac,         e.ec);
                    cmp({e.nm, " err"}, {7'd0, ae}, {7'd0, e.ee});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; in_valid = 1'b0; j = 1'b0; chk_en = 1'b0;
        cur_sel = 1'b0; pv = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        gap(1'b0, 8'd0, "reset");

        // Default overlapping 10010 on 1,0,0,1,0,0,1,0.
        acc(1, 0, 0, 0, "ovl b1"); acc(0, 0, 0, 0, "ovl b2");
        acc(0, 0, 0, 0, "ovl b3"); acc(1, 0, 0, 0, "ovl b4");
        acc(0, 1, 1, 0, "ovl b5"); acc(0, 0, 1, 0, "ovl b6");
        acc(1, 0, 1, 0, "ovl b7"); acc(0, 1, 2, 0, "ovl b8");

        // Asynchronous reset clears a raised w and a non-zero count.
        rst_pulse("async rst");

        // Non-overlapping: bit 8 does not reuse the bits of the first match.
        ld(8'h12, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, "ld novl");
        acc(1, 0, 0, 0, "novl b1"); acc(0, 0, 0, 0, "novl b2");
        acc(0, 0, 0, 0, "novl b3"); acc(1, 0, 0, 0, "novl b4");
        acc(0, 1, 1, 0, "novl b5"); acc(0, 0, 1, 0, "novl b6");
        acc(1, 0, 1, 0, "novl b7"); acc(0, 0, 1, 0, "novl b8");

        // Idle gaps of three cycles between bits.
        ld(8'h12, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, "ld gap");
        acc(1, 0, 0, 0, "gap b1"); repeat (3) gap(0, 8'd0, "gap idle");
        acc(0, 0, 0, 0, "gap b2"); repeat (3) gap(0, 8'd0, "gap idle");
        acc(0, 0, 0, 0, "gap b3"); repeat (3) gap(0, 8'd0, "gap idle");
        acc(1, 0, 0, 0, "gap b4"); repeat (3) gap(0, 8'd0, "gap idle");
        acc(0, 1, 1, 0, "gap b5"); repeat (3) gap(1, 8'd1, "gap hold");
        acc(1, 0, 1, 0, "gap b6");

        // Illegal lengths disable detection until a legal load.
        ld(8'h12, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, "ld len0");
        pv = 8'h12;
        for (int i = 4; i >= 0; i--) acc(pv[i], 0, 0, 1, "len0 acc");
        ld(8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, "ld len1");
        acc(1, 1, 1, 0, "len1 b1"); acc(1, 1, 2, 0, "len1 b2");
        acc(0, 0, 2, 0, "len1 b3"); acc(1, 1, 3, 0, "len1 b4");
        ld(8'h01, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, "ld len9");
        acc(1, 0, 0, 1, "len9 acc");

        // Maximum length pattern A5.
        ld(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, "ld len8");
        pv = 8'hA5;
        for (int i = 7; i >= 0; i--)
            acc(pv[i], (i == 0), (i == 0) ? 8'd1 : 8'd0, 0, "len8 acc");

        // Load with in_valid: the 1 is dropped, so 0,0,1,0 must not match.
        ld(8'h12, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, "ld prio");
        acc(0, 0, 0, 0, "prio b1"); acc(0, 0, 0, 0, "prio b2");
        acc(1, 0, 0, 0, "prio b3"); acc(0, 0, 0, 0, "prio b4");
        acc(1, 0, 0, 0, "pre b1");  acc(0, 0, 0, 0, "pre b2");
        acc(0, 0, 0, 0, "pre b3");  acc(1, 0, 0, 0, "pre b4");

        // Reset after 1,0,0,1: the following 0 would have matched.
        rst_pulse("mid rst");
        acc(0, 0, 0, 0, "post rst 0");
        acc(1, 0, 0, 0, "post b1"); acc(0, 0, 0, 0, "post b2");
        acc(0, 0, 0, 0, "post b3"); acc(1, 0, 0, 0, "post b4");
        acc(0, 1, 1, 0, "post b5");

        // Saturation on the 2-bit counter instance.
        cur_sel = 1'b1;
        ld(8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, "sat ld");
        for (int k = 1; k <= 6; k++)
            acc(1, 1, (k > 3) ? 8'd3 : 8'(k), 0, "sat acc");

        quiet();
        repeat (2) @(negedge clk);
        cmp("scoreboard drained", 8'(sb_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
